// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // Wide enough for any supported data width; sliced to DW/8 at the use site.
    localparam logic [127:0] BE_ALL = '1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side handshakes around the arbiter.
// master: arbiter view. slave: requesters/memory view.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic              i_req;
    logic [AW-1:0]     i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DW-1:0]     i_rdata;

    logic              d_req;
    logic              d_we;
    logic [AW-1:0]     d_addr;
    logic [DW-1:0]     d_wdata;
    logic [DW/8-1:0]   d_be;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DW-1:0]     d_rdata;

    logic              err;
    logic              busy;

    logic              m_req;
    logic              m_we;
    logic [AW-1:0]     m_addr;
    logic [DW-1:0]     m_wdata;
    logic [DW/8-1:0]   m_be;
    logic              m_gnt;
    logic              m_rvalid;
    logic [DW-1:0]     m_rdata;

    modport master (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_gnt, d_rvalid, d_rdata,
        output err, busy,
        output m_req, m_we, m_addr, m_wdata, m_be,
        input  m_gnt, m_rvalid, m_rdata
    );

    modport slave (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_gnt, d_rvalid, d_rdata,
        input  err, busy,
        input  m_req, m_we, m_addr, m_wdata, m_be,
        output m_gnt, m_rvalid, m_rdata
    );

endinterface

// File: rtl/mem_rsp_wdt.sv
// Response watchdog: counts cycles while start is high, expire fires in the
// LIMIT-th counted cycle. Only instantiated when MEM_TIMEOUT_EN is defined.
module mem_rsp_wdt #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic start,
    output logic expire
);
    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;

    assign expire = start && (cnt_q == CW'(LIMIT - 1));

    // Cycle counter, restarted whenever a new response wait begins.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (start && !expire) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch (I) and
// load/store (D). D has priority, bounded by a streak counter so fetch cannot
// starve. Optional response watchdog enabled by the MEM_TIMEOUT_EN macro.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned TIMEOUT_CYC  = 255
) (
    input  logic               clk,
    input  logic               n_rst,
    mem_port_arbiter_if.master bus
);
    localparam int unsigned BW = DW / 8;
    localparam int unsigned SW = $clog2(MAX_D_STREAK + 2);

    if (TIMEOUT_CYC == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be non-zero");
    end

    arb_state_e    state_q;
    owner_e        owner_q;
    logic [SW-1:0] streak_q;
    logic          m_req_q;
    logic          m_we_q;
    logic [AW-1:0] m_addr_q;
    logic [DW-1:0] m_wdata_q;
    logic [BW-1:0] m_be_q;
    logic          i_rvalid_q;
    logic          d_rvalid_q;
    logic [DW-1:0] i_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic          err_q;

    logic force_i;
    logic d_win;
    logic rsp_pending;
    logic wdt_expire;

    // Fetch is forced once D has won MAX_D_STREAK times in a row over a waiting fetch.
    assign force_i     = bus.i_req && (MAX_D_STREAK != 0) && (streak_q == SW'(MAX_D_STREAK));
    assign d_win       = bus.d_req && !force_i;
    // The response pulse is out this cycle; RSP just waits to return to IDLE.
    assign rsp_pending = i_rvalid_q || d_rvalid_q;

`ifdef MEM_TIMEOUT_EN
    mem_rsp_wdt #(
        .LIMIT (TIMEOUT_CYC)
    ) u_wdt (
        .clk    (clk),
        .n_rst  (n_rst),
        .clear  ((state_q == REQ) && bus.m_gnt),
        .start  ((state_q == RSP) && !rsp_pending),
        .expire (wdt_expire)
    );
`else
    assign wdt_expire = 1'b0;
`endif

    // Arbitration, payload capture, handshake FSM and registered responses.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_I;
            streak_q   <= '0;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_be_q     <= '0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            err_q      <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (d_win) begin
                        owner_q   <= OWN_D;
                        m_req_q   <= 1'b1;
                        m_we_q    <= bus.d_we;
                        m_addr_q  <= bus.d_addr;
                        m_wdata_q <= bus.d_wdata;
                        m_be_q    <= bus.d_be;
                        state_q   <= REQ;
                        if (bus.i_req && (streak_q < SW'(MAX_D_STREAK))) begin
                            streak_q <= streak_q + 1'b1;
                        end
                    end else if (bus.i_req) begin
                        owner_q   <= OWN_I;
                        m_req_q   <= 1'b1;
                        m_we_q    <= 1'b0;
                        m_addr_q  <= bus.i_addr;
                        m_wdata_q <= '0;
                        m_be_q    <= BE_ALL[BW-1:0];
                        state_q   <= REQ;
                        streak_q  <= '0;
                    end
                end
                REQ: begin
                    if (bus.m_gnt) begin
                        m_req_q <= 1'b0;
                        state_q <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_pending) begin
                        state_q <= IDLE;
                    end else if (bus.m_rvalid) begin
                        if (owner_q == OWN_I) begin
                            i_rvalid_q <= 1'b1;
                            i_rdata_q  <= bus.m_rdata;
                        end else begin
                            d_rvalid_q <= 1'b1;
                            d_rdata_q  <= m_we_q ? '0 : bus.m_rdata;
                        end
                    end else if (wdt_expire) begin
                        err_q <= 1'b1;
                        if (owner_q == OWN_I) begin
                            i_rvalid_q <= 1'b1;
                            i_rdata_q  <= '0;
                        end else begin
                            d_rvalid_q <= 1'b1;
                            d_rdata_q  <= '0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Grants follow the memory accept in the same cycle.
    assign bus.i_gnt    = (state_q == REQ) && bus.m_gnt && (owner_q == OWN_I);
    assign bus.d_gnt    = (state_q == REQ) && bus.m_gnt && (owner_q == OWN_D);
    assign bus.i_rvalid = i_rvalid_q;
    assign bus.i_rdata  = i_rdata_q;
    assign bus.d_rvalid = d_rvalid_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.err      = err_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.m_req    = m_req_q;
    assign bus.m_we     = m_we_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_wdata  = m_wdata_q;
    assign bus.m_be     = m_be_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter (MAX_D_STREAK=4, TIMEOUT_CYC=8).
// The timeout sequence is compiled only when MEM_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   n_vec = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(
        .AW           (32),
        .DW           (32),
        .MAX_D_STREAK (4),
        .TIMEOUT_CYC  (8)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] mem_rdata;
        int          gnt_delay;
        logic        exp_we;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t       vecs[5];
    logic [1:0] exp_order[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
    endtask

    // One complete transaction from request to response, checked cycle by cycle.
    task automatic run_txn(input vec_t v);
        if (v.is_d) begin
            bus.d_req   = 1'b1;
            bus.d_we    = v.we;
            bus.d_addr  = v.addr;
            bus.d_wdata = v.wdata;
            bus.d_be    = v.be;
        end else begin
            bus.i_req  = 1'b1;
            bus.i_addr = v.addr;
        end
        @(negedge clk);
        chk({v.name, " busy cycle0"}, 64'(bus.busy), 64'd0);
        next_cycle();
        for (int k = 0; k < v.gnt_delay; k++) begin
            @(negedge clk);
            chk({v.name, " m_req held"}, 64'(bus.m_req), 64'd1);
            chk({v.name, " m_addr held"}, 64'(bus.m_addr), 64'(v.addr));
            chk({v.name, " no gnt while waiting"}, 64'({bus.i_gnt, bus.d_gnt}), 64'd0);
            next_cycle();
        end
        bus.m_gnt = 1'b1;
        @(negedge clk);
        chk({v.name, " i_gnt"}, 64'(bus.i_gnt), 64'(!v.is_d));
        chk({v.name, " d_gnt"}, 64'(bus.d_gnt), 64'(v.is_d));
        chk({v.name, " m_req"}, 64'(bus.m_req), 64'd1);
        chk({v.name, " m_addr"}, 64'(bus.m_addr), 64'(v.addr));
        chk({v.name, " m_we"}, 64'(bus.m_we), 64'(v.exp_we));
        chk({v.name, " m_be"}, 64'(bus.m_be), 64'(v.exp_be));
        chk({v.name, " m_wdata"}, 64'(bus.m_wdata), 64'(v.exp_wdata));
        next_cycle();
        bus.i_req    = 1'b0;
        bus.d_req    = 1'b0;
        bus.m_gnt    = 1'b0;
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = v.mem_rdata;
        @(negedge clk);
        chk({v.name, " m_req dropped"}, 64'(bus.m_req), 64'd0);
        chk({v.name, " no early rvalid"}, 64'({bus.i_rvalid, bus.d_rvalid}), 64'd0);
        next_cycle();
        bus.m_rvalid = 1'b0;
        bus.m_rdata  = 32'hFFFF_FFFF;
        @(negedge clk);
        chk({v.name, " rvalid"}, 64'({bus.i_rvalid, bus.d_rvalid}),
            v.is_d ? 64'd1 : 64'd2);
        chk({v.name, " rdata"}, 64'(v.is_d ? bus.d_rdata : bus.i_rdata), 64'(v.exp_rdata));
        chk({v.name, " err"}, 64'(bus.err), 64'd0);
        chk({v.name, " busy rsp"}, 64'(bus.busy), 64'd1);
        next_cycle();
        @(negedge clk);
        chk({v.name, " rvalid single pulse"}, 64'({bus.i_rvalid, bus.d_rvalid}), 64'd0);
        chk({v.name, " busy idle"}, 64'(bus.busy), 64'd0);
        next_cycle();
    endtask

    initial begin
        int grants;
        logic g_d, g_i;

        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
        bus.m_gnt = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = '0;

        vecs[0] = '{"fetch", 1'b0, 1'b0, 32'h1000_0000, 32'h0, 4'h0, 32'h0000_0013, 0,
                    1'b0, 32'h0, 4'hF, 32'h0000_0013};
        vecs[1] = '{"store", 1'b1, 1'b1, 32'h2000_0004, 32'h0000_A5A5, 4'b0011, 32'hDEAD_BEEF, 0,
                    1'b1, 32'h0000_A5A5, 4'b0011, 32'h0};
        vecs[2] = '{"load", 1'b1, 1'b0, 32'h2000_0008, 32'h1234_5678, 4'hF, 32'hCAFE_F00D, 2,
                    1'b0, 32'h1234_5678, 4'hF, 32'hCAFE_F00D};
        vecs[3] = '{"fetch_slow_gnt", 1'b0, 1'b0, 32'h1000_0004, 32'h0, 4'h0, 32'h0050_0093, 5,
                    1'b0, 32'h0, 4'hF, 32'h0050_0093};
        vecs[4] = '{"load_byte", 1'b1, 1'b0, 32'h2000_0010, 32'h0, 4'b0100, 32'h1122_3344, 1,
                    1'b0, 32'h0, 4'b0100, 32'h1122_3344};
        for (int k = 0; k < 10; k++) exp_order[k] = (k == 4 || k == 9) ? 2'b01 : 2'b10;

        // Reset state
        #2;
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset m_req", 64'(bus.m_req), 64'd0);
        chk("reset rvalid", 64'({bus.i_rvalid, bus.d_rvalid, bus.err}), 64'd0);
        apply_reset();

        for (int i = 0; i < 5; i++) run_txn(vecs[i]);

        // Read data holds across the other requester's traffic
        chk("i_rdata hold", 64'(bus.i_rdata), 64'h0050_0093);
        chk("d_rdata hold", 64'(bus.d_rdata), 64'h1122_3344);

        // Contention: both requests held, immediate gnt, response one cycle later
        apply_reset();
        bus.i_req = 1'b1; bus.i_addr = 32'h1000_0100;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h2000_0100; bus.d_be = 4'hF;
        bus.m_gnt = 1'b1; bus.m_rdata = 32'h0000_0077;
        grants = 0;
        for (int cyc = 0; cyc < 80 && grants < 10; cyc++) begin
            @(negedge clk);
            g_d = bus.d_gnt;
            g_i = bus.i_gnt;
            if (g_d || g_i) begin
                chk($sformatf("contention grant %0d", grants), 64'({g_d, g_i}),
                    64'(exp_order[grants]));
                grants++;
            end
            next_cycle();
            bus.m_rvalid = g_d || g_i;
        end
        chk("contention grant count", 64'(grants), 64'd10);
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        next_cycle();
        bus.m_rvalid = 1'b0; bus.m_gnt = 1'b0;
        repeat (3) next_cycle();

        // Asynchronous reset while in RSP, then a stray response
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h3000_0000; bus.d_be = 4'hF;
        next_cycle();
        bus.m_gnt = 1'b1;
        next_cycle();
        bus.d_req = 1'b0; bus.m_gnt = 1'b0;
        @(negedge clk);
        chk("pre-reset busy", 64'(bus.busy), 64'd1);
        #1;
        n_rst = 1'b0;
        #1;
        chk("reset busy async", 64'(bus.busy), 64'd0);
        chk("reset m_addr async", 64'(bus.m_addr), 64'd0);
        chk("reset d_rdata async", 64'(bus.d_rdata), 64'd0);
        chk("reset pulses async", 64'({bus.m_req, bus.i_gnt, bus.d_gnt, bus.i_rvalid,
                                       bus.d_rvalid, bus.err}), 64'd0);
        next_cycle();
        n_rst = 1'b1;
        bus.m_rvalid = 1'b1; bus.m_rdata = 32'h0000_0BAD;
        @(negedge clk);
        chk("stray rvalid busy", 64'(bus.busy), 64'd0);
        next_cycle();
        bus.m_rvalid = 1'b0;
        @(negedge clk);
        chk("stray rvalid ignored", 64'({bus.i_rvalid, bus.d_rvalid}), 64'd0);
        next_cycle();

`ifdef MEM_TIMEOUT_EN
        // Watchdog: no response after the grant
        run_txn(vecs[2]);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h4000_0000; bus.d_be = 4'hF;
        next_cycle();
        bus.m_gnt = 1'b1;
        next_cycle();
        bus.d_req = 1'b0; bus.m_gnt = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("timeout wait %0d", k), 64'(bus.d_rvalid), 64'd0);
            next_cycle();
        end
        @(negedge clk);
        chk("timeout d_rvalid", 64'(bus.d_rvalid), 64'd1);
        chk("timeout err", 64'(bus.err), 64'd1);
        chk("timeout d_rdata", 64'(bus.d_rdata), 64'd0);
        next_cycle();
        bus.m_rvalid = 1'b1; bus.m_rdata = 32'h0000_1A7E;
        @(negedge clk);
        chk("timeout back to idle", 64'(bus.busy), 64'd0);
        next_cycle();
        bus.m_rvalid = 1'b0;
        @(negedge clk);
        chk("late rvalid ignored", 64'({bus.d_rvalid, bus.err}), 64'd0);
        chk("late rdata ignored", 64'(bus.d_rdata), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
